// File: rtl/spi_pkg.sv
// Shared constants and state type for the oversampled SPI mode-0 slave.
package spi_pkg;

  localparam bit SPI_CPOL    = 1'b0;
  localparam bit SPI_CPHA    = 1'b0;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise/fall
// pulses derived from the synchronized level and a one-cycle delayed copy.
module spi_edge_sync
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] pipe;
  logic                   dly;

  // Resetting to 0 means a pin held low through reset never produces an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
      dly  <= 1'b0;
    end else begin
      pipe <= {pipe[SYNC_STAGES-2:0], din};
      dly  <= pipe[SYNC_STAGES-1];
    end
  end

  assign rise = pipe[SYNC_STAGES-1] & ~dly;
  assign fall = ~pipe[SYNC_STAGES-1] & dly;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave, MSB first, running entirely in the system clock domain;
// one-word holding register on transmit, single-cycle strobe on receive.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ss,
  input  logic            sck,
  input  logic            mosi,
  output logic            miso,
  input  logic [size-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [size-1:0] rx_data,
  output logic            rx_valid,
  output logic            busy,
  output logic            underrun,
  output logic            abort
);

  localparam int            CW   = $clog2(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic                   ss_rise, ss_fall, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   mosi_s;
  spi_state_e             state;
  logic [size-1:0]        holding, tx_shift, rx_shift, load_word;
  logic [CW-1:0]          bit_cnt;
  logic                   start_frame, end_frame, do_rise, do_fall, word_done, load_now;

  spi_edge_sync u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ss),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_edge_sync u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_pipe <= '0;
    end else begin
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  // An ss rise in the same cycle as an sck edge suppresses the edge.
  always_comb begin
    start_frame = 1'b0;
    end_frame   = 1'b0;
    do_rise     = 1'b0;
    do_fall     = 1'b0;
    case (state)
      SPI_IDLE: begin
        start_frame = ss_fall;
      end
      SPI_ACTIVE: begin
        end_frame = ss_rise;
        do_rise   = sck_rise & ~ss_rise;
        do_fall   = sck_fall & ~ss_rise;
      end
      default: begin
        start_frame = 1'b0;
      end
    endcase
    word_done = do_rise && (bit_cnt == LAST);
    load_now  = start_frame | word_done;
    if (tx_ready) begin
      load_word = '0;
    end else begin
      load_word = holding;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SPI_IDLE;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      miso     <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
      holding  <= '0;
      tx_ready <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;

      if (start_frame) begin
        state   <= SPI_ACTIVE;
        busy    <= 1'b1;
        bit_cnt <= '0;
      end else if (end_frame) begin
        state   <= SPI_IDLE;
        busy    <= 1'b0;
        bit_cnt <= '0;
        miso    <= 1'b0;
        abort   <= (bit_cnt != '0);
      end else if (do_rise) begin
        rx_shift <= {rx_shift[size-2:0], mosi_s};
        if (word_done) begin
          rx_data  <= {rx_shift[size-2:0], mosi_s};
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + ONE;
        end
      end else if (do_fall && (bit_cnt != '0)) begin
        // The fall straight after a word boundary keeps the freshly loaded MSB.
        tx_shift <= {tx_shift[size-2:0], 1'b0};
        miso     <= tx_shift[size-2];
      end

      if (load_now) begin
        tx_shift <= load_word;
        miso     <= load_word[size-1];
        underrun <= tx_ready;
        tx_ready <= 1'b1;
      end

      // A handshake coinciding with a load only fills holding; it is placed
      // last so it overrides the load's tx_ready update.
      if (tx_valid && tx_ready) begin
        holding  <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: a mode-0 master drives frames, a monitor
// checks rx strobes against queued words, and a word-level model predicts miso.
module tb_spi_slave_sync;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst, ss, sck, mosi, miso;
  logic [SIZE-1:0] tx_data, rx_data;
  logic            tx_valid, tx_ready, rx_valid, busy, underrun, abort;

  int tests = 0;
  int fails = 0;
  int n_rx = 0, n_under = 0, n_abort = 0;
  int exp_rx = 0, exp_under = 0, exp_abort = 0;

  logic [SIZE-1:0] rx_exp_q[$];
  logic [SIZE-1:0] hold_model[$];
  logic [SIZE-1:0] mo_buf[4];

  always #5 clk = ~clk;

  spi_slave_sync #(.size(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .underrun (underrun),
    .abort    (abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Word the slave sends at a load: the held word if any, otherwise zero plus an underrun.
  function automatic logic [SIZE-1:0] model_load();
    if (hold_model.size() != 0) return hold_model.pop_front();
    exp_under++;
    return '0;
  endfunction

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rx++;
      if (rx_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got %0h expected no strobe", rx_data);
      end else begin
        check("rx_data", rx_data, rx_exp_q.pop_front());
      end
    end
    if (underrun) n_under++;
    if (abort) n_abort++;
  end

  task automatic offer(input logic [SIZE-1:0] v);
    int n;
    n = 0;
    tx_data  = v;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    if (n >= 500) begin
      check("offer_timeout", 32'd0, 32'd1);
    end else begin
      tick(1);
      hold_model.push_back(v);
    end
    tx_valid = 1'b0;
  endtask

  // Frame of nw words (mo_buf), the last one cut to bits_last bits; sck = clk/16.
  task automatic spi_frame(input int nw, input int bits_last);
    logic [SIZE-1:0] mi, exp_mi;
    int nb;
    ss = 1'b0;
    for (int w = 0; w < nw; w++) begin
      exp_mi = model_load();
      nb = (w == nw - 1) ? bits_last : SIZE;
      if (nb == SIZE) begin
        rx_exp_q.push_back(mo_buf[w]);
        exp_rx++;
      end
      mi = '0;
      for (int b = 0; b < nb; b++) begin
        mosi = mo_buf[w][SIZE-1-b];
        tick(8);
        if (w == 0 && b == 0) begin
          check("busy_active", busy, 1);
          check("tx_ready_after_load", tx_ready, hold_model.size() == 0);
          check("underrun_at_ss_fall", n_under, exp_under);
        end
        sck = 1'b1;
        mi = {mi[SIZE-2:0], miso};
        tick(8);
        sck = 1'b0;
      end
      if (nb == SIZE) check("miso_word", mi, exp_mi);
    end
    if (bits_last == SIZE) void'(model_load());
    else exp_abort++;
    tick(8);
    ss = 1'b1;
    mosi = 1'b0;
    tick(8);
    check("miso_idle", miso, 0);
    check("busy_idle", busy, 0);
    check("underrun_count", n_under, exp_under);
    check("abort_count", n_abort, exp_abort);
    check("rx_count", n_rx, exp_rx);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, bl;
    bit mid;
    rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    tick(4);
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_abort", abort, 0);
    rst = 1'b0;
    tick(4);

    // ss high: sck activity is ignored
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom);
      sck = 1'b1; tick(8);
      check("idle_miso_hi", miso, 0);
      sck = 1'b0; tick(8);
      check("idle_miso_lo", miso, 0);
    end
    check("idle_rx_count", n_rx, 0);
    check("idle_tx_ready", tx_ready, 1);
    check("idle_busy", busy, 0);

    // preload A5, master sends 3C
    offer(8'hA5);
    check("tx_ready_full", tx_ready, 0);
    mo_buf[0] = 8'h3C;
    spi_frame(1, SIZE);
    check("tx_ready_end", tx_ready, 1);

    // two words back to back, second offered after the first load
    offer(8'h11);
    mo_buf[0] = 8'hF0;
    mo_buf[1] = 8'h0F;
    fork
      spi_frame(2, SIZE);
      begin tick(20); offer(8'h22); end
    join

    // no preload: zero word with underrun at ss fall
    mo_buf[0] = 8'h96;
    spi_frame(1, SIZE);

    // abort after 3 bits, then a clean frame
    offer(8'h5C);
    mo_buf[0] = 8'hE7;
    spi_frame(1, 3);
    offer(8'hC4);
    mo_buf[0] = 8'h81;
    spi_frame(1, SIZE);

    // reset mid-frame with 5A pending in holding
    ss = 1'b0;
    void'(model_load());
    tick(8);
    offer(8'h5A);
    for (int b = 0; b < 5; b++) begin
      mosi = 1'($urandom);
      tick(8); sck = 1'b1;
      tick(8); sck = 1'b0;
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    hold_model.delete();
    check("mid_rst_miso", miso, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick(4);
    ss = 1'b1;
    tick(10);
    check("mid_rst_no_abort", n_abort, exp_abort);
    check("mid_rst_busy_after", busy, 0);
    mo_buf[0] = 8'h3A;
    spi_frame(1, SIZE);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      nw  = $urandom_range(1, 3);
      bl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, SIZE - 1) : SIZE;
      mid = (nw >= 2) && ($urandom_range(0, 1) == 1);
      for (int w = 0; w < 4; w++) mo_buf[w] = SIZE'($urandom);
      if ($urandom_range(0, 1) == 1 && hold_model.size() == 0) offer(SIZE'($urandom));
      fork
        spi_frame(nw, bl);
        begin if (mid) begin tick(20); offer(SIZE'($urandom)); end end
      join
    end

    tick(20);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
